// File: rtl/mp64_extmem_arb.sv
// mp64_extmem_arb -- four-requester round-robin arbiter in front of a single
// external-memory CPU port.
//
// Optional feature macro: MP64_ARB_TIMEOUT_EN
//   When defined, a watchdog counts BUSY cycles. After TIMEOUT_CYCLES without
//   m_ack the granted requester receives err_o and ack_o together, and the
//   arbiter parks in DRAIN to swallow one late m_ack before releasing the port.
//   When undefined, there is no counter and no DRAIN state, err_o is tied to 0,
//   and BUSY waits for m_ack indefinitely.
//
// Ports
//   clk      : sole clock, rising edge
//   rst_n    : synchronous active-low reset
//   req_i    : per-requester level request
//   addr_i   : 4x64 byte addresses, requester k at [k*64 +: 64]
//   wdata_i  : 4x64 write data, same packing
//   wen_i    : per-requester write enable
//   size_i   : 4x2 access size, requester k at [k*2 +: 2]
//   rdata_o  : registered read data shared by all requesters
//   ack_o    : one-cycle completion pulse for the granted requester
//   err_o    : one-cycle timeout pulse for the granted requester
//   m_req    : request to the downstream port (BUSY and no m_ack this cycle)
//   m_addr, m_wdata, m_wen, m_size : payload latched on the grant edge
//   m_rdata  : downstream read data
//   m_ack    : downstream one-cycle completion pulse
module mp64_extmem_arb #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [3:0]   req_i,
  input  logic [255:0] addr_i,
  input  logic [255:0] wdata_i,
  input  logic [3:0]   wen_i,
  input  logic [7:0]   size_i,
  output logic [63:0]  rdata_o,
  output logic [3:0]   ack_o,
  output logic [3:0]   err_o,
  output logic         m_req,
  output logic [63:0]  m_addr,
  output logic [63:0]  m_wdata,
  output logic         m_wen,
  output logic [1:0]   m_size,
  input  logic [63:0]  m_rdata,
  input  logic         m_ack
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSY    = 2'd1,
    ST_RELEASE = 2'd2
`ifdef MP64_ARB_TIMEOUT_EN
    , ST_DRAIN = 2'd3
`endif
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  rr_ptr_q, rr_ptr_d;
  logic [1:0]  gnt_idx_q, gnt_idx_d;
  logic [3:0]  ack_q, ack_d;
  logic [63:0] rdata_q, rdata_d;
  logic [63:0] m_addr_q, m_addr_d;
  logic [63:0] m_wdata_q, m_wdata_d;
  logic        m_wen_q, m_wen_d;
  logic [1:0]  m_size_q, m_size_d;
  logic [2:0]  pick_s;
  logic [3:0]  gnt_onehot_s;

`ifdef MP64_ARB_TIMEOUT_EN
  // Counter only has to hold 0 .. TIMEOUT_CYCLES-1.
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       err_q, err_d;
`endif

  // Returns {valid, index} of the first set request at or above ptr, wrapping 3->0.
  // The loop runs from the farthest offset down so the nearest hit wins.
  function automatic logic [2:0] rr_pick(input logic [3:0] req, input logic [1:0] ptr);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int i = 3; i >= 0; i--) begin
      idx = ptr + 2'(i);
      if (req[idx]) begin
        res = {1'b1, idx};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  // Arbitration choice and one-hot of the current grant.
  always_comb begin
    pick_s       = rr_pick(req_i, rr_ptr_q);
    gnt_onehot_s = 4'b0001 << gnt_idx_q;
  end

  // Next-state and next-output logic for the transaction FSM.
  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    gnt_idx_d = gnt_idx_q;
    ack_d     = 4'b0000;
    rdata_d   = rdata_q;
    m_addr_d  = m_addr_q;
    m_wdata_d = m_wdata_q;
    m_wen_d   = m_wen_q;
    m_size_d  = m_size_q;
`ifdef MP64_ARB_TIMEOUT_EN
    cnt_d     = cnt_q;
    err_d     = 4'b0000;
`endif
    case (state_q)
      ST_IDLE: begin
        if (pick_s[2]) begin
          gnt_idx_d = pick_s[1:0];
          rr_ptr_d  = pick_s[1:0] + 2'd1;
          m_addr_d  = addr_i[{pick_s[1:0], 6'd0} +: 64];
          m_wdata_d = wdata_i[{pick_s[1:0], 6'd0} +: 64];
          m_wen_d   = wen_i[pick_s[1:0]];
          m_size_d  = size_i[{pick_s[1:0], 1'b0} +: 2];
          state_d   = ST_BUSY;
`ifdef MP64_ARB_TIMEOUT_EN
          cnt_d     = '0;
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (m_ack) begin
          rdata_d = m_rdata;
          ack_d   = gnt_onehot_s;
          state_d = ST_RELEASE;
        end else begin
`ifdef MP64_ARB_TIMEOUT_EN
          // The compare hits during the TIMEOUT_CYCLES-th BUSY cycle.
          if (cnt_q == CNT_LAST) begin
            err_d   = gnt_onehot_s;
            ack_d   = gnt_onehot_s;
            cnt_d   = '0;
            state_d = ST_DRAIN;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
`else
          state_d = ST_BUSY;
`endif
        end
      end
      ST_RELEASE: begin
        // One dead cycle lets a requester drop req_i before the next arbitration.
        state_d = ST_IDLE;
      end
`ifdef MP64_ARB_TIMEOUT_EN
      ST_DRAIN: begin
        // A late m_ack belongs to the abandoned access: discard its data.
        if (m_ack) begin
          state_d = ST_RELEASE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_RELEASE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
`endif
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      rr_ptr_q  <= 2'd0;
      gnt_idx_q <= 2'd0;
      ack_q     <= 4'b0000;
      rdata_q   <= 64'd0;
      m_addr_q  <= 64'd0;
      m_wdata_q <= 64'd0;
      m_wen_q   <= 1'b0;
      m_size_q  <= 2'd0;
`ifdef MP64_ARB_TIMEOUT_EN
      cnt_q     <= '0;
      err_q     <= 4'b0000;
`endif
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      gnt_idx_q <= gnt_idx_d;
      ack_q     <= ack_d;
      rdata_q   <= rdata_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
      m_wen_q   <= m_wen_d;
      m_size_q  <= m_size_d;
`ifdef MP64_ARB_TIMEOUT_EN
      cnt_q     <= cnt_d;
      err_q     <= err_d;
`endif
    end
  end

  // Request is withdrawn in the ack cycle so the controller never sees a re-issue.
  assign m_req   = (state_q == ST_BUSY) && !m_ack;
  assign ack_o   = ack_q;
  assign rdata_o = rdata_q;
  assign m_addr  = m_addr_q;
  assign m_wdata = m_wdata_q;
  assign m_wen   = m_wen_q;
  assign m_size  = m_size_q;
`ifdef MP64_ARB_TIMEOUT_EN
  assign err_o   = err_q;
`else
  assign err_o   = 4'b0000;
`endif

endmodule

// File: tb/tb_mp64_extmem_arb.sv
// Directed, table-driven bench for mp64_extmem_arb (TIMEOUT_CYCLES = 8).
module tb_mp64_extmem_arb;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   req_i;
  logic [255:0] addr_i;
  logic [255:0] wdata_i;
  logic [3:0]   wen_i;
  logic [7:0]   size_i;
  logic [63:0]  rdata_o;
  logic [3:0]   ack_o;
  logic [3:0]   err_o;
  logic         m_req;
  logic [63:0]  m_addr;
  logic [63:0]  m_wdata;
  logic         m_wen;
  logic [1:0]   m_size;
  logic [63:0]  m_rdata;
  logic         m_ack;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mp64_extmem_arb #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst_n(rst_n), .req_i(req_i), .addr_i(addr_i), .wdata_i(wdata_i),
    .wen_i(wen_i), .size_i(size_i), .rdata_o(rdata_o), .ack_o(ack_o), .err_o(err_o),
    .m_req(m_req), .m_addr(m_addr), .m_wdata(m_wdata), .m_wen(m_wen), .m_size(m_size),
    .m_rdata(m_rdata), .m_ack(m_ack)
  );

  typedef struct {
    logic        rst_n;
    logic [3:0]  req;
    logic        ack;
    logic [63:0] rd;
    logic        exp_mreq;   // m_req with these inputs, before the edge
    logic [3:0]  exp_ack;    // after the edge
    logic [63:0] exp_rdata;  // after the edge
    int          exp_gnt;    // payload owner after the edge, 4 = reset zeros
  } vec_t;

  vec_t vecs[$];

  localparam logic [3:0] WEN_PAT = 4'b1010;

  function automatic logic [63:0] exp_addr(int g);
    return (g == 4) ? 64'd0 : 64'h0000_0000_1000_0000 + 64'(g) * 64'h100;
  endfunction
  function automatic logic [63:0] exp_wdata(int g);
    return (g == 4) ? 64'd0 : 64'hA5A5_0000_0000_0000 | 64'(g);
  endfunction
  function automatic logic exp_wen(int g);
    logic [3:0] p;
    p = WEN_PAT;
    return (g == 4) ? 1'b0 : p[g];
  endfunction
  function automatic logic [1:0] exp_size(int g);
    return (g == 4) ? 2'd0 : 2'(g);
  endfunction

  function automatic void add(logic r, logic [3:0] rq, logic a, logic [63:0] rd,
                              logic em, logic [3:0] ea, logic [63:0] er, int eg);
    vec_t v;
    v.rst_n = r; v.req = rq; v.ack = a; v.rd = rd;
    v.exp_mreq = em; v.exp_ack = ea; v.exp_rdata = er; v.exp_gnt = eg;
    vecs.push_back(v);
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_payload(string tag, int g);
    chk({tag, " m_addr"},  m_addr,  exp_addr(g));
    chk({tag, " m_wdata"}, m_wdata, exp_wdata(g));
    chk({tag, " m_wen"},   64'(m_wen),  64'(exp_wen(g)));
    chk({tag, " m_size"},  64'(m_size), 64'(exp_size(g)));
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [63:0] prev_rd;
    logic [63:0] r;
    int g;

    rst_n = 1'b0; req_i = 4'b0000; m_ack = 1'b0; m_rdata = 64'd0;
    wen_i = WEN_PAT; size_i = 8'b11_10_01_00;
    for (int k = 0; k < 4; k++) begin
      addr_i[k*64 +: 64]  = exp_addr(k);
      wdata_i[k*64 +: 64] = exp_wdata(k);
    end

    // Reset state
    tick; tick;
    chk("reset m_req", 64'(m_req), 64'd0);
    chk("reset ack_o", 64'(ack_o), 64'd0);
    chk("reset err_o", 64'(err_o), 64'd0);
    chk("reset rdata_o", rdata_o, 64'd0);
    chk_payload("reset", 4);
    rst_n = 1'b1;

    // Single access: m_ack five cycles after m_req rises
    add(1'b1, 4'b0001, 1'b0, 64'd0, 1'b0, 4'b0000, 64'd0, 0);
    for (int i = 0; i < 5; i++) add(1'b1, 4'b0001, 1'b0, 64'd0, 1'b1, 4'b0000, 64'd0, 0);
    add(1'b1, 4'b0001, 1'b1, 64'hDEAD_BEEF, 1'b0, 4'b0001, 64'hDEAD_BEEF, 0);
    add(1'b1, 4'b0000, 1'b0, 64'd0, 1'b0, 4'b0000, 64'hDEAD_BEEF, 0);
    add(1'b1, 4'b0000, 1'b0, 64'd0, 1'b0, 4'b0000, 64'hDEAD_BEEF, 0);

    // Round robin from a fresh reset: grants 0,1,2,3,0 with immediate acks
    add(1'b0, 4'b0000, 1'b0, 64'd0, 1'b0, 4'b0000, 64'd0, 4);
    prev_rd = 64'd0;
    for (int n = 0; n < 5; n++) begin
      g = n % 4;
      r = 64'h1000 + 64'(n);
      add(1'b1, 4'b1111, 1'b0, 64'd0, 1'b0, 4'b0000, prev_rd, g);
      add(1'b1, 4'b1111, 1'b1, r,     1'b0, 4'b0001 << g, r, g);
      add(1'b1, 4'b1111, 1'b0, 64'd0, 1'b0, 4'b0000, r, g);
      prev_rd = r;
    end

    // Pointer wrap: grant 2 leaves rr_ptr=3, then 0101 must pick 0
    add(1'b0, 4'b0000, 1'b0, 64'd0, 1'b0, 4'b0000, 64'd0, 4);
    add(1'b1, 4'b0100, 1'b0, 64'd0, 1'b0, 4'b0000, 64'd0, 2);
    add(1'b1, 4'b0100, 1'b1, 64'h2222, 1'b0, 4'b0100, 64'h2222, 2);
    add(1'b1, 4'b0101, 1'b0, 64'd0, 1'b0, 4'b0000, 64'h2222, 2);
    add(1'b1, 4'b0101, 1'b0, 64'd0, 1'b0, 4'b0000, 64'h2222, 0);
    add(1'b1, 4'b0101, 1'b1, 64'h3333, 1'b0, 4'b0001, 64'h3333, 0);
    add(1'b1, 4'b0000, 1'b0, 64'd0, 1'b0, 4'b0000, 64'h3333, 0);

    // Reset mid-BUSY: no pulse, then rr_ptr back at 0 (1111 grants 0, not 1)
    add(1'b1, 4'b0010, 1'b0, 64'd0, 1'b0, 4'b0000, 64'h3333, 1);
    add(1'b1, 4'b0010, 1'b0, 64'd0, 1'b1, 4'b0000, 64'h3333, 1);
    add(1'b0, 4'b0010, 1'b0, 64'd0, 1'b1, 4'b0000, 64'd0, 4);
    add(1'b1, 4'b1111, 1'b0, 64'd0, 1'b0, 4'b0000, 64'd0, 0);
    add(1'b1, 4'b1111, 1'b1, 64'h4444, 1'b0, 4'b0001, 64'h4444, 0);
    add(1'b1, 4'b0000, 1'b0, 64'd0, 1'b0, 4'b0000, 64'h4444, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      rst_n = vecs[i].rst_n; req_i = vecs[i].req;
      m_ack = vecs[i].ack;   m_rdata = vecs[i].rd;
      #1;
      chk($sformatf("v%0d m_req", i), 64'(m_req), 64'(vecs[i].exp_mreq));
      tick;
      chk($sformatf("v%0d ack_o", i), 64'(ack_o), 64'(vecs[i].exp_ack));
      chk($sformatf("v%0d err_o", i), 64'(err_o), 64'd0);
      chk($sformatf("v%0d rdata_o", i), rdata_o, vecs[i].exp_rdata);
      chk_payload($sformatf("v%0d", i), vecs[i].exp_gnt);
    end
    rst_n = 1'b1; m_ack = 1'b0; req_i = 4'b0000;

    // m_ack in IDLE is ignored
    m_ack = 1'b1; m_rdata = 64'hBAD; tick;
    chk("idle ack ack_o", 64'(ack_o), 64'd0);
    chk("idle ack rdata_o", rdata_o, 64'h4444);
    m_ack = 1'b0;

    // Payload stable and req_i ignored while BUSY
    req_i = 4'b1000; tick;
    addr_i[3*64 +: 64] = 64'hFFFF_0000_0000_0000; req_i = 4'b0001;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk_payload("busy hold", 3);
      chk("busy hold m_req", 64'(m_req), 64'd1);
      chk("busy hold ack_o", 64'(ack_o), 64'd0);
    end
    m_ack = 1'b1; m_rdata = 64'h5555; #1;
    chk("ack cycle m_req", 64'(m_req), 64'd0);
    tick;
    chk("req3 ack_o", 64'(ack_o), 64'b1000);
    chk("req3 rdata_o", rdata_o, 64'h5555);
    m_ack = 1'b0; req_i = 4'b0000; addr_i[3*64 +: 64] = exp_addr(3);
    tick;
    chk("req3 ack_o one cycle", 64'(ack_o), 64'd0);
    chk("no reissue m_req", 64'(m_req), 64'd0);
    tick;

`ifdef MP64_ARB_TIMEOUT_EN
    // Watchdog: no m_ack for 8 BUSY cycles, then a late m_ack in DRAIN
    req_i = 4'b0001; tick; req_i = 4'b0000;
    for (int i = 1; i < 8; i++) begin
      tick;
      chk($sformatf("to c%0d err_o", i), 64'(err_o), 64'd0);
      chk($sformatf("to c%0d m_req", i), 64'(m_req), 64'd1);
    end
    tick;
    chk("timeout err_o", 64'(err_o), 64'b0001);
    chk("timeout ack_o", 64'(ack_o), 64'b0001);
    chk("drain m_req", 64'(m_req), 64'd0);
    m_ack = 1'b1; m_rdata = 64'h7777; #1;
    chk("drain m_req w/ ack", 64'(m_req), 64'd0);
    tick;
    m_ack = 1'b0;
    chk("late ack err_o", 64'(err_o), 64'd0);
    chk("late ack ack_o", 64'(ack_o), 64'd0);
    chk("late ack rdata_o", rdata_o, 64'h5555);
    tick;
    chk("after drain m_req", 64'(m_req), 64'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
